// File: rtl/forward_sched_pkg.sv
// ---------------------------------------------------------------------------
// forward_sched_pkg
// Shared types and helpers for the forward_scheduler slice.
//   state_e    : scheduler FSM state (IDLE, HOLD)
//   chanWidth  : index width for n requesters, never narrower than one bit
//   SEQ_WRAP   : modulus of the default-width sequence counter
// ---------------------------------------------------------------------------
package forward_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam int unsigned SEQW_DEFAULT = 8;
    // fwdSeq is an unsigned SEQW-bit counter, so it returns to 0 after this many grants.
    localparam int unsigned SEQ_WRAP     = 1 << SEQW_DEFAULT;

    // max(1, clog2(n)): a single requester still needs a one-bit index port.
    function automatic int chanWidth(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/forward_scheduler_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Purely combinational circular priority picker. Returns the first set bit of
// eligible_i at or above ptr_i, wrapping around to index 0.
//   eligible_i  [N]   candidate mask
//   ptr_i       [CHW] search start index (always < N)
//   any_valid_o [1]   at least one candidate present
//   winner_o    [CHW] selected index (0 when no candidate)
// ---------------------------------------------------------------------------
module rr_pick
    import forward_sched_pkg::*;
#(
    parameter int N   = 4,
    parameter int CHW = chanWidth(N)
) (
    input  logic [N-1:0]   eligible_i,
    input  logic [CHW-1:0] ptr_i,
    output logic           any_valid_o,
    output logic [CHW-1:0] winner_o
);

    logic           hi_any;
    logic [CHW-1:0] hi_win;
    logic [CHW-1:0] lo_win;

    // Two passes: lowest candidate at/above the pointer wins; otherwise the
    // lowest candidate overall, which is the first one after wrapping.
    always_comb begin
        hi_any = 1'b0;
        hi_win = '0;
        lo_win = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (eligible_i[i]) begin
                lo_win = CHW'(i);
                if (i >= int'(ptr_i)) begin
                    hi_any = 1'b1;
                    hi_win = CHW'(i);
                end
            end
        end
    end

    assign any_valid_o = |eligible_i;
    assign winner_o    = hi_any ? hi_win : lo_win;

endmodule

// File: rtl/forward_scheduler.sv
// ---------------------------------------------------------------------------
// forward_scheduler
// Round-robin scheduler sharing one strobe-less CDC forwarding channel among
// NCHAN requesters. Each granted word is held stable for HOLD_CYCLES cycles
// and tagged with channel index and a sequence number so the far side can
// detect a new word by a change of fwdSeq.
//
// Handshake: a requester raises reqValid[i] with its payload on
// reqData[i*WIDTH +: WIDTH] and holds reqValid until it sees the one-cycle
// reqAck[i] pulse. The payload is captured on the grant edge only; reqAck
// and the new fwdData/fwdChan/fwdSeq appear together one cycle later. A
// requester that drops reqValid before being granted is simply never acked.
//
// Ports:
//   clk       in   source-domain clock
//   rstN      in   asynchronous active-low reset
//   reqValid  in   [NCHAN]        per-requester request
//   reqData   in   [NCHAN*WIDTH]  per-requester payloads
//   reqAck    out  [NCHAN]        one-cycle capture acknowledge
//   fwdData   out  [WIDTH]        held payload
//   fwdChan   out  [CHW]          granted requester index
//   fwdSeq    out  [SEQW]         increments on every grant
//   fwdBusy   out  1              word is inside its hold window
//   dbgState  out  state_e        current FSM state
// ---------------------------------------------------------------------------
module forward_scheduler
    import forward_sched_pkg::*;
#(
    parameter int NCHAN       = 4,
    parameter int WIDTH       = 32,
    parameter int SEQW        = SEQW_DEFAULT,
    parameter int HOLD_CYCLES = 8,
    localparam int CHW        = chanWidth(NCHAN)
) (
    input  logic                   clk,
    input  logic                   rstN,
    input  logic [NCHAN-1:0]       reqValid,
    input  logic [NCHAN*WIDTH-1:0] reqData,
    output logic [NCHAN-1:0]       reqAck,
    output logic [WIDTH-1:0]       fwdData,
    output logic [CHW-1:0]         fwdChan,
    output logic [SEQW-1:0]        fwdSeq,
    output logic                   fwdBusy,
    output state_e                 dbgState
);

    // holdCount never exceeds HOLD_CYCLES-1, so clog2(HOLD_CYCLES) bits suffice.
    localparam int             HCW       = chanWidth(HOLD_CYCLES);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);

    if (HOLD_CYCLES < 2) begin : g_hold_check
        $fatal(1, "forward_scheduler: HOLD_CYCLES must be at least 2");
    end

    state_e                 state_q, state_d;
    logic [HCW-1:0]         hold_q,  hold_d;
    logic [CHW-1:0]         ptr_q,   ptr_d;
    logic [WIDTH-1:0]       data_q,  data_d;
    logic [CHW-1:0]         chan_q,  chan_d;
    logic [SEQW-1:0]        seq_q,   seq_d;
    logic [NCHAN-1:0]       ack_q,   ack_d;
    logic                   busy_q,  busy_d;

    logic [NCHAN-1:0]       eligible;
    logic                   any_valid;
    logic [CHW-1:0]         winner;
    logic                   grant;

    // A requester whose ack is on the wire this cycle has already been
    // served; masking it stops a second grant before it can drop reqValid.
    assign eligible = reqValid & ~ack_q;

    rr_pick #(
        .N   (NCHAN),
        .CHW (CHW)
    ) u_pick (
        .eligible_i  (eligible),
        .ptr_i       (ptr_q),
        .any_valid_o (any_valid),
        .winner_o    (winner)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= IDLE;
            hold_q  <= '0;
            ptr_q   <= '0;
            data_q  <= '0;
            chan_q  <= '0;
            seq_q   <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            seq_q   <= seq_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        chan_d  = chan_q;
        seq_d   = seq_q;
        busy_d  = busy_q;
        ack_d   = '0;
        grant   = 1'b0;

        case (state_q)
            IDLE: grant = any_valid;
            HOLD: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - 1'b1;
                end else if (any_valid) begin
                    // Back-to-back grant: spacing stays exactly HOLD_CYCLES.
                    grant = 1'b1;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (grant) begin
            for (int i = 0; i < NCHAN; i++) begin
                if (winner == CHW'(i)) begin
                    data_d   = reqData[i*WIDTH +: WIDTH];
                    ack_d[i] = 1'b1;
                end
            end
            chan_d  = winner;
            seq_d   = seq_q + 1'b1;
            ptr_d   = (winner == CHW'(NCHAN - 1)) ? '0 : winner + 1'b1;
            hold_d  = HOLD_LAST;
            state_d = HOLD;
            busy_d  = 1'b1;
        end
    end

    assign reqAck   = ack_q;
    assign fwdData  = data_q;
    assign fwdChan  = chan_q;
    assign fwdSeq   = seq_q;
    assign fwdBusy  = busy_q;
    assign dbgState = state_q;

endmodule

// File: tb/tb_forward_scheduler.sv
// ---------------------------------------------------------------------------
// tb_forward_scheduler
// Bench for forward_scheduler. The main instance (4 channels, hold 8) is
// compared every cycle against a time-based reference: a grant may happen at
// edge c only if c >= last_grant + H, the winner is the first requesting
// channel circularly from the pointer, and the word stays busy for H cycles.
// A second instance (1 channel, hold 2) covers the degenerate case.
// ---------------------------------------------------------------------------
module tb_forward_scheduler;
    import forward_sched_pkg::*;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int SW = 8;
    localparam int H  = 8;
    localparam int H1 = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    // ---------------- main DUT ----------------
    logic [N-1:0]   reqValid;
    logic [N*W-1:0] reqData;
    logic [N-1:0]   reqAck;
    logic [W-1:0]   fwdData;
    logic [1:0]     fwdChan;
    logic [SW-1:0]  fwdSeq;
    logic           fwdBusy;
    state_e         dbgState;

    forward_scheduler #(
        .NCHAN(N), .WIDTH(W), .SEQW(SW), .HOLD_CYCLES(H)
    ) dut (
        .clk(clk), .rstN(rstN),
        .reqValid(reqValid), .reqData(reqData), .reqAck(reqAck),
        .fwdData(fwdData), .fwdChan(fwdChan), .fwdSeq(fwdSeq),
        .fwdBusy(fwdBusy), .dbgState(dbgState)
    );

    // ---------------- single-channel DUT ----------------
    logic          v1;
    logic [W-1:0]  d1;
    logic          ack1;
    logic [W-1:0]  data1;
    logic          chan1;
    logic [SW-1:0] seq1;
    logic          busy1;
    state_e        st1;

    forward_scheduler #(
        .NCHAN(1), .WIDTH(W), .SEQW(SW), .HOLD_CYCLES(H1)
    ) dut1 (
        .clk(clk), .rstN(rstN),
        .reqValid(v1), .reqData(d1), .reqAck(ack1),
        .fwdData(data1), .fwdChan(chan1), .fwdSeq(seq1),
        .fwdBusy(busy1), .dbgState(st1)
    );

    // ---------------- scoreboard / reference state ----------------
    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_q[$];
    int           cyc;
    int           m_ptr;
    int           m_seq;
    logic [W-1:0] m_data;
    int           m_chan;
    int           m_last_grant;
    logic [N-1:0] m_ack;
    int           grants;
    int           ack_cyc;
    int           busy_low_cnt;
    int           ack_hist[N];
    int           prev_seq_obs;
    logic         seen_wrap;
    logic         keep_valid;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] get_slice(input int i);
        return W'(reqData >> (i * W));
    endfunction

    task automatic set_data(input int i, input logic [W-1:0] val);
        logic [N*W-1:0] mask;
        mask    = {{((N - 1) * W){1'b0}}, {W{1'b1}}} << (i * W);
        reqData = (reqData & ~mask) | ((N * W)'(val) << (i * W));
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rstN     = 1'b0;
        reqValid = '0;
        v1       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstN         = 1'b1;
        cyc          = 0;
        m_ptr        = 0;
        m_seq        = 0;
        m_data       = '0;
        m_chan       = 0;
        m_last_grant = -H;
        m_ack        = '0;
        exp_q.delete();
        prev_seq_obs = 0;
        keep_valid   = 1'b0;
    endtask

    // Predict the coming edge, advance one clock, compare, then let
    // requesters react to their acks.
    task automatic step();
        logic [N-1:0] elig;
        int           win;
        logic         exp_busy;
        elig = reqValid & ~m_ack;
        win  = -1;
        if (cyc >= m_last_grant + H) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (win < 0 && ((elig >> idx) & N'(1)) != '0) win = idx;
            end
        end
        m_ack = '0;
        if (win >= 0) begin
            m_data       = get_slice(win);
            m_chan       = win;
            m_seq        = (m_seq + 1) % SEQ_WRAP;
            m_ack        = N'(1) << win;
            m_ptr        = (win + 1) % N;
            m_last_grant = cyc;
            exp_q.push_back(m_data);
            grants++;
        end

        @(posedge clk);
        #1;
        exp_busy = (cyc < m_last_grant + H);
        check_eq("ack",   reqAck,   m_ack);
        check_eq("data",  fwdData,  m_data);
        check_eq("chan",  fwdChan,  m_chan);
        check_eq("seq",   fwdSeq,   m_seq);
        check_eq("busy",  fwdBusy,  exp_busy);
        check_eq("state", dbgState, exp_busy ? HOLD : IDLE);
        if (reqAck != '0) begin
            ack_cyc = cyc;
            check_eq("sb_depth", 64'(exp_q.size()), 64'd1);
            if (exp_q.size() != 0) check_eq("sb_word", fwdData, exp_q.pop_front());
        end
        if (!fwdBusy) busy_low_cnt++;
        if (prev_seq_obs == 255 && fwdSeq == '0) seen_wrap = 1'b1;
        prev_seq_obs = int'(fwdSeq);

        for (int i = 0; i < N; i++) begin
            if (reqAck[i]) begin
                ack_hist[i]++;
                if (keep_valid) set_data(i, $urandom);
                else            reqValid[i] = 1'b0;
            end
        end
        cyc++;
    endtask

    task automatic run_until_ack(input string tag, output int ch);
        int n;
        ch = -1;
        n  = 0;
        while (ch < 0 && n < 64) begin
            step();
            n++;
            for (int i = 0; i < N; i++) if (reqAck[i]) ch = i;
        end
        check_eq({tag, "_ack_seen"}, (ch >= 0), 1'b1);
    endtask

    task automatic drive_random();
        for (int i = 0; i < N; i++) begin
            if (!reqValid[i]) begin
                if ($urandom_range(0, 3) != 0) begin
                    reqValid[i] = 1'b1;
                    set_data(i, $urandom);
                end
            end else if ($urandom_range(0, 31) == 0) begin
                reqValid[i] = 1'b0;          // withdrawal
            end else if ($urandom_range(0, 15) == 0) begin
                set_data(i, $urandom);       // only the grant-edge value matters
            end
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete (bad=%0d)", bad);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int           ch;
        int           prev_cyc;
        int           n;
        logic         prev_ack;
        logic [W-1:0] exp_d;

        rstN       = 1'b0;
        reqValid   = '0;
        reqData    = '0;
        v1         = 1'b0;
        d1         = '0;
        grants     = 0;
        seen_wrap  = 1'b0;
        keep_valid = 1'b0;
        busy_low_cnt = 0;
        for (int i = 0; i < N; i++) ack_hist[i] = 0;
        do_reset();

        // Reset state of both instances.
        check_eq("rst_ack",   reqAck,   0);
        check_eq("rst_data",  fwdData,  0);
        check_eq("rst_chan",  fwdChan,  0);
        check_eq("rst_seq",   fwdSeq,   0);
        check_eq("rst_busy",  fwdBusy,  0);
        check_eq("rst_state", dbgState, IDLE);
        check_eq("rst1_ack",  ack1,     0);
        check_eq("rst1_seq",  seq1,     0);
        check_eq("rst1_busy", busy1,    0);

        // Single request on ch2 from idle.
        set_data(2, 32'hDEADBEEF);
        reqValid[2] = 1'b1;
        run_until_ack("single", ch);
        check_eq("single_ack",  reqAck,  4'b0100);
        check_eq("single_data", fwdData, 32'hDEADBEEF);
        check_eq("single_chan", fwdChan, 2);
        check_eq("single_seq",  fwdSeq,  1);
        step();
        check_eq("single_ack_pulse", reqAck, 0);
        repeat (6) step();
        check_eq("single_busy_last", fwdBusy, 1);
        step();
        check_eq("single_busy_end",  fwdBusy,  0);
        check_eq("single_idle",      dbgState, IDLE);
        check_eq("single_data_kept", fwdData,  32'hDEADBEEF);

        // Full contention from pointer 0.
        do_reset();
        keep_valid = 1'b1;
        for (int i = 0; i < N; i++) set_data(i, $urandom);
        reqValid = '1;
        busy_low_cnt = 0;
        prev_cyc = 0;
        for (int g = 0; g < 5; g++) begin
            run_until_ack("cont", ch);
            check_eq("cont_chan", ch, g % N);
            check_eq("cont_seq", fwdSeq, g + 1);
            if (g > 0) check_eq("cont_spacing", ack_cyc - prev_cyc, H);
            prev_cyc = ack_cyc;
        end
        check_eq("cont_busy_low", busy_low_cnt, 0);
        keep_valid = 1'b0;
        reqValid   = '0;

        // Fairness: after ch1 the pointer is 2, so ch3 beats ch1.
        do_reset();
        set_data(1, $urandom);
        reqValid[1] = 1'b1;
        run_until_ack("fair_first", ch);
        check_eq("fair_first_chan", ch, 1);
        set_data(1, $urandom);
        set_data(3, $urandom);
        reqValid[1] = 1'b1;
        reqValid[3] = 1'b1;
        run_until_ack("fair_a", ch);
        check_eq("fair_a_chan", ch, 3);
        run_until_ack("fair_b", ch);
        check_eq("fair_b_chan", ch, 1);
        reqValid = '0;

        // Withdrawal: ch0 requests briefly during ch3's hold.
        do_reset();
        for (int i = 0; i < N; i++) ack_hist[i] = 0;
        set_data(3, $urandom);
        reqValid[3] = 1'b1;
        run_until_ack("wd", ch);
        check_eq("wd_chan", ch, 3);
        repeat (2) step();
        set_data(0, $urandom);
        reqValid[0] = 1'b1;
        repeat (2) step();
        reqValid[0] = 1'b0;
        repeat (10) step();
        check_eq("wd_ch0_acks", ack_hist[0], 0);
        check_eq("wd_seq",      fwdSeq,      1);
        check_eq("wd_idle",     dbgState,    IDLE);

        // Reset in the middle of a hold window.
        do_reset();
        set_data(1, 32'h12345678);
        reqValid[1] = 1'b1;
        run_until_ack("mid", ch);
        check_eq("mid_data", fwdData, 32'h12345678);
        repeat (2) step();
        #2;
        rstN = 1'b0;
        #1;
        check_eq("mid_rst_ack",   reqAck,   0);
        check_eq("mid_rst_data",  fwdData,  0);
        check_eq("mid_rst_chan",  fwdChan,  0);
        check_eq("mid_rst_seq",   fwdSeq,   0);
        check_eq("mid_rst_busy",  fwdBusy,  0);
        check_eq("mid_rst_state", dbgState, IDLE);
        do_reset();
        set_data(0, $urandom);
        set_data(2, $urandom);
        reqValid = 4'b0101;
        run_until_ack("post_rst", ch);
        check_eq("post_rst_chan", ch, 0);
        check_eq("post_rst_seq",  fwdSeq, 1);
        reqValid = '0;

        // Random traffic long enough to wrap the sequence counter.
        do_reset();
        grants    = 0;
        seen_wrap = 1'b0;
        n         = 0;
        while (grants < 270 && n < 4000) begin
            drive_random();
            step();
            n++;
        end
        check_eq("rand_grants", (grants >= 270), 1'b1);
        check_eq("seq_wrap",    seen_wrap,       1'b1);
        reqValid = '0;
        repeat (H + 2) step();
        check_eq("sb_left", 64'(exp_q.size()), 0);

        // Single channel, hold 2, request held high.
        do_reset();
        v1       = 1'b1;
        d1       = $urandom;
        prev_ack = 1'b0;
        exp_d    = '0;
        for (int k = 0; k < 20; k++) begin
            if (k % 2 == 0) exp_d = d1;
            @(posedge clk);
            #1;
            check_eq("n1_ack",      ack1,            (k % 2 == 0));
            check_eq("n1_no_b2b",   prev_ack & ack1, 1'b0);
            check_eq("n1_seq",      seq1,            k / 2 + 1);
            check_eq("n1_data",     data1,           exp_d);
            check_eq("n1_chan",     chan1,           1'b0);
            check_eq("n1_busy",     busy1,           1'b1);
            prev_ack = ack1;
            d1       = $urandom;
        end
        v1 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
